// File: rtl/video_pkg.sv
// Shared constants for the RGB<->YCbCr video converters: BT.601 coefficients
// scaled by 32, chroma offset and the field layout of the 24-bit video word.
package video_pkg;

    localparam int CR_R  = 45;
    localparam int CB_G  = 11;
    localparam int CR_G  = 23;
    localparam int CB_B  = 57;
    localparam int C_OFS = 16;

    localparam int Y_MSB  = 7;
    localparam int Y_LSB  = 3;
    localparam int CB_MSB = 15;
    localparam int CB_LSB = 11;
    localparam int CR_MSB = 23;
    localparam int CR_LSB = 19;

    localparam int FIELD_W = 5;
    localparam int SUM_W   = 12;
    localparam int CH_W    = 8;
    localparam int WORD_W  = 24;

    // Replicate the top bits so 0 maps to 8'h00 and 31 maps to 8'hFF.
    function automatic logic [CH_W-1:0] expand5(input logic [FIELD_W-1:0] c5);
        return {c5, c5[4:2]};
    endfunction

endpackage

// File: rtl/ycc_chan_sat.sv
// One colour channel: clamps a signed 32x-scaled sum to 5 bits and widens it to 8.
module ycc_chan_sat
    import video_pkg::*;
(
    input  logic signed [SUM_W-1:0] i_sum,
    output logic [CH_W-1:0]         o_chan
);

    logic signed [SUM_W-1:0] w_shr;
    logic [FIELD_W-1:0]      w_c5;

    assign w_shr = i_sum >>> 3'd5;

    // Negative sums clamp to black, anything at or above 32 units clamps to full scale.
    always_comb begin
        w_c5 = 5'd0;
        if (i_sum[SUM_W-1]) begin
            w_c5 = 5'd0;
        end else if (w_shr > 12'sd31) begin
            w_c5 = 5'd31;
        end else begin
            w_c5 = w_shr[FIELD_W-1:0];
        end
    end

    assign o_chan = expand5(w_c5);

endmodule

// File: rtl/ycbcr_to_rgb.sv
// AXI4-Stream 5-bit YCbCr to 8-bit RGB converter: stallable 3-stage pipeline
// with a bit-exact bypass path and tlast/tuser carried alongside each beat.
module ycbcr_to_rgb
    import video_pkg::*;
#(
    parameter int CR_R = video_pkg::CR_R,
    parameter int CB_G = video_pkg::CB_G,
    parameter int CR_G = video_pkg::CR_G,
    parameter int CB_B = video_pkg::CB_B
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        Sel,
    input  logic [23:0] s_axis_video_tdata,
    input  logic        s_axis_video_tvalid,
    output logic        s_axis_video_tready,
    input  logic        s_axis_video_tlast,
    input  logic        s_axis_video_tuser,
    output logic [23:0] m_axis_video_tdata,
    output logic        m_axis_video_tvalid,
    input  logic        m_axis_video_tready,
    output logic        m_axis_video_tlast,
    output logic        m_axis_video_tuser
);

    localparam logic signed [SUM_W-1:0] K_CR_R = SUM_W'(CR_R);
    localparam logic signed [SUM_W-1:0] K_CB_G = SUM_W'(CB_G);
    localparam logic signed [SUM_W-1:0] K_CR_G = SUM_W'(CR_G);
    localparam logic signed [SUM_W-1:0] K_CB_B = SUM_W'(CB_B);

    logic w_ce;

    logic [FIELD_W-1:0]        w_cb5;
    logic [FIELD_W-1:0]        w_cr5;
    logic signed [FIELD_W:0]   w_dcb;
    logic signed [FIELD_W:0]   w_dcr;

    logic                      r_s1_valid;
    logic                      r_s1_sel;
    logic                      r_s1_last;
    logic                      r_s1_user;
    logic [WORD_W-1:0]         r_s1_raw;
    logic [FIELD_W-1:0]        r_s1_y;
    logic signed [FIELD_W:0]   r_s1_dcb;
    logic signed [FIELD_W:0]   r_s1_dcr;

    logic signed [SUM_W-1:0]   w_dcb_x;
    logic signed [SUM_W-1:0]   w_dcr_x;

    logic                      r_s2_valid;
    logic                      r_s2_sel;
    logic                      r_s2_last;
    logic                      r_s2_user;
    logic [WORD_W-1:0]         r_s2_raw;
    logic [9:0]                r_s2_y32;
    logic signed [SUM_W-1:0]   r_s2_p_cr_r;
    logic signed [SUM_W-1:0]   r_s2_p_cb_g;
    logic signed [SUM_W-1:0]   r_s2_p_cr_g;
    logic signed [SUM_W-1:0]   r_s2_p_cb_b;

    logic signed [SUM_W-1:0]   w_y32_s;
    logic signed [SUM_W-1:0]   w_sum_r;
    logic signed [SUM_W-1:0]   w_sum_g;
    logic signed [SUM_W-1:0]   w_sum_b;
    logic [CH_W-1:0]           w_r8;
    logic [CH_W-1:0]           w_g8;
    logic [CH_W-1:0]           w_b8;

    logic                      r_s3_valid;
    logic                      r_s3_last;
    logic                      r_s3_user;
    logic [WORD_W-1:0]         r_s3_tdata;

    // The whole pipeline advances together whenever the output slot is free or draining.
    assign w_ce                = !r_s3_valid || m_axis_video_tready;
    assign s_axis_video_tready = w_ce;

    assign w_cb5 = s_axis_video_tdata[CB_MSB:CB_LSB];
    assign w_cr5 = s_axis_video_tdata[CR_MSB:CR_LSB];
    assign w_dcb = {1'b0, w_cb5} - 6'(C_OFS);
    assign w_dcr = {1'b0, w_cr5} - 6'(C_OFS);

    // Stage 1: capture luma, centred chroma and the raw word for bypass.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_sel   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_user  <= 1'b0;
            r_s1_raw   <= 24'h000000;
            r_s1_y     <= 5'd0;
            r_s1_dcb   <= 6'sd0;
            r_s1_dcr   <= 6'sd0;
        end else if (w_ce) begin
            r_s1_valid <= s_axis_video_tvalid;
            r_s1_sel   <= Sel;
            r_s1_last  <= s_axis_video_tlast;
            r_s1_user  <= s_axis_video_tuser;
            r_s1_raw   <= s_axis_video_tdata;
            r_s1_y     <= s_axis_video_tdata[Y_MSB:Y_LSB];
            r_s1_dcb   <= w_dcb;
            r_s1_dcr   <= w_dcr;
        end
    end

    assign w_dcb_x = $signed({{(SUM_W-FIELD_W-1){r_s1_dcb[FIELD_W]}}, r_s1_dcb});
    assign w_dcr_x = $signed({{(SUM_W-FIELD_W-1){r_s1_dcr[FIELD_W]}}, r_s1_dcr});

    // Stage 2: scaled luma and the four chroma products.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s2_valid  <= 1'b0;
            r_s2_sel    <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_user   <= 1'b0;
            r_s2_raw    <= 24'h000000;
            r_s2_y32    <= 10'd0;
            r_s2_p_cr_r <= 12'sd0;
            r_s2_p_cb_g <= 12'sd0;
            r_s2_p_cr_g <= 12'sd0;
            r_s2_p_cb_b <= 12'sd0;
        end else if (w_ce) begin
            r_s2_valid  <= r_s1_valid;
            r_s2_sel    <= r_s1_sel;
            r_s2_last   <= r_s1_last;
            r_s2_user   <= r_s1_user;
            r_s2_raw    <= r_s1_raw;
            r_s2_y32    <= {r_s1_y, 5'd0};
            r_s2_p_cr_r <= K_CR_R * w_dcr_x;
            r_s2_p_cb_g <= K_CB_G * w_dcb_x;
            r_s2_p_cr_g <= K_CR_G * w_dcr_x;
            r_s2_p_cb_b <= K_CB_B * w_dcb_x;
        end
    end

    // Sums never exceed 12-bit signed range for 5-bit inputs and these coefficients.
    assign w_y32_s = $signed({2'b00, r_s2_y32});
    assign w_sum_r = w_y32_s + r_s2_p_cr_r;
    assign w_sum_g = w_y32_s - r_s2_p_cb_g - r_s2_p_cr_g;
    assign w_sum_b = w_y32_s + r_s2_p_cb_b;

    ycc_chan_sat u_sat_r (.i_sum(w_sum_r), .o_chan(w_r8));
    ycc_chan_sat u_sat_g (.i_sum(w_sum_g), .o_chan(w_g8));
    ycc_chan_sat u_sat_b (.i_sum(w_sum_b), .o_chan(w_b8));

    // Stage 3: output register, holds its beat while the consumer stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s3_valid <= 1'b0;
            r_s3_last  <= 1'b0;
            r_s3_user  <= 1'b0;
            r_s3_tdata <= 24'h000000;
        end else if (w_ce) begin
            r_s3_valid <= r_s2_valid;
            r_s3_last  <= r_s2_last;
            r_s3_user  <= r_s2_user;
            r_s3_tdata <= r_s2_sel ? r_s2_raw : {w_r8, w_b8, w_g8};
        end
    end

    assign m_axis_video_tvalid = r_s3_valid;
    assign m_axis_video_tdata  = r_s3_tdata;
    assign m_axis_video_tlast  = r_s3_last;
    assign m_axis_video_tuser  = r_s3_user;

endmodule
